// File: rtl/uart_tx_arbiter.sv
// Two-requester, message-atomic arbiter in front of a single uart_tx.
// Ownership lasts from grant until the owner's end-of-message byte is forwarded or it times out.
module uart_tx_arbiter #(
    parameter logic [7:0] EOM_BYTE = 8'h0A,
    parameter int         TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       u_require,
    output logic [7:0] u_data,
    output logic       u_valid,
    input  logic       req0,
    output logic       require0,
    input  logic [7:0] data0,
    input  logic       valid0,
    input  logic       req1,
    output logic       require1,
    input  logic [7:0] data1,
    input  logic       valid1,
    output logic [1:0] grant,
    output logic       timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic             pending;
    logic             waiting;
    logic             prio1;
    logic [CNT_W-1:0] wait_cnt;
    logic             g_valid;
    logic [7:0]       g_data;

    // Byte strobe and data of whichever requester currently owns the uart.
    always_comb begin
        g_valid = 1'b0;
        g_data  = 8'h00;
        if (grant[0]) begin
            g_valid = valid0;
            g_data  = data0;
        end else if (grant[1]) begin
            g_valid = valid1;
            g_data  = data1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            u_data      <= 8'h00;
            u_valid     <= 1'b0;
            require0    <= 1'b0;
            require1    <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= 1'b0;
            waiting     <= 1'b0;
            wait_cnt    <= '0;
            prio1       <= 1'b0;
        end else begin
            u_valid     <= 1'b0;
            require0    <= 1'b0;
            require1    <= 1'b0;
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                // A uart request seen with no owner is held for the next grant.
                if (u_require)
                    pending <= 1'b1;
                if (req0 || req1) begin
                    state <= GRANT;
                    if (req0 && (!prio1 || !req1))
                        grant <= 2'b01;
                    else
                        grant <= 2'b10;
                end
            end else begin
                if (!waiting) begin
                    if (u_require || pending) begin
                        require0 <= grant[0];
                        require1 <= grant[1];
                        waiting  <= 1'b1;
                        wait_cnt <= '0;
                        pending  <= 1'b0;
                    end
                end else if (g_valid) begin
                    u_data  <= g_data;
                    u_valid <= 1'b1;
                    waiting <= 1'b0;
                    if (g_data == EOM_BYTE) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        prio1 <= grant[0];
                    end
                end else if (wait_cnt == CNT_LAST) begin
                    // Owner went silent: drop it and carry the uart's request forward.
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                    grant       <= 2'b00;
                    prio1       <= grant[0];
                    pending     <= 1'b1;
                    waiting     <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_arbiter;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       u_require = 1'b0;
    logic [7:0] u_data;
    logic       u_valid;
    logic       req0 = 1'b0, valid0 = 1'b0, require0;
    logic       req1 = 1'b0, valid1 = 1'b0, require1;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic [1:0] grant;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(.EOM_BYTE(8'h0A), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .u_require(u_require), .u_data(u_data), .u_valid(u_valid),
        .req0(req0), .require0(require0), .data0(data0), .valid0(valid0),
        .req1(req1), .require1(require1), .data1(data1), .valid1(valid1),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
        n_tests++; if (u_valid !== 1'b0 || u_data !== 8'h00) begin n_fail++; $display("FAIL reset_udata got v=%b d=%h want v=0 d=00", u_valid, u_data); end
        n_tests++; if ({require0, require1, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {require0, require1, timeout_err}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rr_first_grant got %b want 01", grant); end
        u_require = 1'b1; tick(); u_require = 1'b0;
        n_tests++; if ({require0, require1} !== 2'b10) begin n_fail++; $display("FAIL rr_require0 got %b want 10", {require0, require1}); end
        valid0 = 1'b1; data0 = 8'h41; tick(); valid0 = 1'b0;
        n_tests++; if (u_valid !== 1'b1 || u_data !== 8'h41) begin n_fail++; $display("FAIL rr_byte_A got v=%b d=%h want v=1 d=41", u_valid, u_data); end
        tick();
        n_tests++; if (u_valid !== 1'b0) begin n_fail++; $display("FAIL rr_valid_pulse got %b want 0", u_valid); end
        u_require = 1'b1; tick(); u_require = 1'b0;
        valid0 = 1'b1; data0 = 8'h0A; tick(); valid0 = 1'b0;
        n_tests++; if (u_valid !== 1'b1 || u_data !== 8'h0A || grant !== 2'b00) begin n_fail++; $display("FAIL rr_eom got v=%b d=%h g=%b want v=1 d=0a g=00", u_valid, u_data, grant); end
        tick();
        n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rr_second_grant got %b want 10", grant); end
        req0 = 1'b0; req1 = 1'b0;
        u_require = 1'b1; tick(); u_require = 1'b0;
        n_tests++; if ({require0, require1} !== 2'b01) begin n_fail++; $display("FAIL rr_require1 got %b want 01", {require0, require1}); end
        valid1 = 1'b1; data1 = 8'h0A; tick(); valid1 = 1'b0;
        n_tests++; if (grant !== 2'b00 || u_data !== 8'h0A) begin n_fail++; $display("FAIL rr_release1 got g=%b d=%h want g=00 d=0a", grant, u_data); end
    endtask

    task automatic test_pending;
        u_require = 1'b1; tick(); u_require = 1'b0;
        tick();
        n_tests++; if ({require0, require1, grant} !== 4'b0000) begin n_fail++; $display("FAIL pend_idle got %b want 0000", {require0, require1, grant}); end
        req1 = 1'b1; tick();
        n_tests++; if (grant !== 2'b10 || require1 !== 1'b0) begin n_fail++; $display("FAIL pend_grant got g=%b r1=%b want g=10 r1=0", grant, require1); end
        tick();
        n_tests++; if (require1 !== 1'b1) begin n_fail++; $display("FAIL pend_require1 got %b want 1", require1); end
        tick();
        n_tests++; if (require1 !== 1'b0) begin n_fail++; $display("FAIL pend_once got %b want 0", require1); end
        valid1 = 1'b1; data1 = 8'h0A; tick(); valid1 = 1'b0; req1 = 1'b0;
        n_tests++; if (u_valid !== 1'b1 || grant !== 2'b00) begin n_fail++; $display("FAIL pend_release got v=%b g=%b want v=1 g=00", u_valid, grant); end
    endtask

    task automatic test_timeout;
        int n = 0;
        req0 = 1'b1; tick();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL to_grant got %b want 01", grant); end
        u_require = 1'b1; tick(); u_require = 1'b0;
        n_tests++; if (require0 !== 1'b1) begin n_fail++; $display("FAIL to_require0 got %b want 1", require0); end
        req1 = 1'b1;
        for (int i = 1; i <= 2 * TO; i++) begin
            tick();
            if (timeout_err === 1'b1) begin n = i; break; end
        end
        n_tests++; if (n != TO) begin n_fail++; $display("FAIL to_latency got %0d want %0d", n, TO); end
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_grant_idle got %b want 00", grant); end
        req0 = 1'b0; tick();
        n_tests++; if (grant !== 2'b10 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_next_grant got g=%b te=%b want g=10 te=0", grant, timeout_err); end
        tick();
        n_tests++; if (require1 !== 1'b1) begin n_fail++; $display("FAIL to_pending_require1 got %b want 1", require1); end
        valid1 = 1'b1; data1 = 8'h0A; tick(); valid1 = 1'b0; req1 = 1'b0;
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_release got %b want 00", grant); end
    endtask

    task automatic test_ignore_foreign;
        req0 = 1'b1; tick();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL ign_grant got %b want 01", grant); end
        u_require = 1'b1; tick(); u_require = 1'b0;
        valid1 = 1'b1; data1 = 8'h55; tick(); valid1 = 1'b0;
        n_tests++; if (u_valid !== 1'b0) begin n_fail++; $display("FAIL ign_foreign_valid got %b want 0", u_valid); end
        valid0 = 1'b1; data0 = 8'h42; tick(); valid0 = 1'b0;
        n_tests++; if (u_valid !== 1'b1 || u_data !== 8'h42) begin n_fail++; $display("FAIL ign_owner_byte got v=%b d=%h want v=1 d=42", u_valid, u_data); end
        valid0 = 1'b1; data0 = 8'h0A; tick(); valid0 = 1'b0;
        n_tests++; if (u_valid !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL ign_unrequested got v=%b g=%b want v=0 g=01", u_valid, grant); end
        u_require = 1'b1; tick(); u_require = 1'b0;
        valid0 = 1'b1; data0 = 8'h0A; tick(); valid0 = 1'b0; req0 = 1'b0;
        n_tests++; if (u_valid !== 1'b1 || grant !== 2'b00) begin n_fail++; $display("FAIL ign_release got v=%b g=%b want v=1 g=00", u_valid, grant); end
    endtask

    task automatic test_reset_mid_message;
        req0 = 1'b1; req1 = 1'b1; tick();
        n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rst_pre_grant got %b want 10", grant); end
        for (int b = 1; b <= 3; b++) begin
            u_require = 1'b1; tick(); u_require = 1'b0;
            valid1 = 1'b1; data1 = 8'(b); tick(); valid1 = 1'b0;
        end
        n_tests++; if (u_data !== 8'h03) begin n_fail++; $display("FAIL rst_third_byte got %h want 03", u_data); end
        u_require = 1'b1; tick(); u_require = 1'b0;
        valid1 = 1'b1; data1 = 8'h04; rst_n = 1'b0; tick(); valid1 = 1'b0;
        n_tests++; if (grant !== 2'b00 || u_valid !== 1'b0 || u_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_outputs got g=%b v=%b d=%h want g=00 v=0 d=00", grant, u_valid, u_data); end
        n_tests++; if ({require0, require1, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_pulses got %b want 000", {require0, require1, timeout_err}); end
        rst_n = 1'b1; tick();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_rearb got %b want 01", grant); end
        tick();
        n_tests++; if (require0 !== 1'b0) begin n_fail++; $display("FAIL rst_no_pending got %b want 0", require0); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_round_robin();
        test_pending();
        test_timeout();
        test_ignore_foreign();
        test_reset_mid_message();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
